// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
// Merges the CPU core's instruction-fetch and data-access request streams
// onto one single-port synchronous memory. Both CPU ports use a split
// req/addr_ok/data_ok handshake. A fixed-latency tag pipeline remembers who
// issued each access, and each response is returned to that owner in
// acceptance order.
//
// Arbitration: the data port has priority. If inst has been denied in favour
// of data ARB_STARVE times in a row, inst is force-granted once.
//
// Optional build macro: SRAM_ARB_KSEG_MAP_EN
//   When defined, mem_addr = {3'b000, winner_addr[28:0]}, so kseg0/kseg1
//   addresses fold onto physical addresses.
//   When undefined, mem_addr is the winner's address unmodified.
//
// Parameters:
//   RD_LAT     - memory read latency in cycles; stores are acknowledged after
//                the same latency (>=1)
//   MAX_OUT    - maximum outstanding accesses per requester (>=1)
//   ARB_STARVE - consecutive inst losses before inst is forced through (>=1)
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   inst_req/addr       - fetch request (read only)
//   inst_addr_ok        - fetch request accepted this cycle
//   inst_data_ok/rdata  - fetch response
//   data_req/wen/addr/wdata - load/store request (wen == 0 means load)
//   data_addr_ok        - data request accepted this cycle
//   data_data_ok/rdata  - load data, or store completion with rdata = 0
//   mem_en/wen/addr/wdata - memory command, one per accepted request
//   mem_rdata           - memory read data, valid RD_LAT cycles after mem_en
module sram_req_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int MAX_OUT    = 2,
  parameter int ARB_STARVE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(ARB_STARVE + 1);

  // Tag pipeline, one bit-vector per field. Index 0 is the newest access;
  // index RD_LAT-1 is the access whose memory data is on mem_rdata now.
  // owner: 1 = data port, 0 = inst port. wr: access was a store.
  logic [RD_LAT-1:0] tag_valid_reg, tag_valid_next;
  logic [RD_LAT-1:0] tag_owner_reg, tag_owner_next;
  logic [RD_LAT-1:0] tag_wr_reg,    tag_wr_next;

  logic [CW-1:0] inst_cnt_reg, inst_cnt_next;
  logic [CW-1:0] data_cnt_reg, data_cnt_next;
  logic [SW-1:0] starve_reg,   starve_next;

  logic inst_retire, data_retire, tail_wr;
  logic inst_room, data_room;
  logic inst_elig, data_elig;
  logic inst_grant, data_grant, accept, force_inst;
  logic [31:0] win_addr;

  // Retirement comes from the tail of the tag pipeline. Gating it with rst
  // keeps every response output at zero while reset is held.
  assign tail_wr     = tag_wr_reg[RD_LAT-1];
  assign inst_retire = !rst && tag_valid_reg[RD_LAT-1] && !tag_owner_reg[RD_LAT-1];
  assign data_retire = !rst && tag_valid_reg[RD_LAT-1] &&  tag_owner_reg[RD_LAT-1];

  // A requester that is full may still be accepted if it retires a response
  // in the same cycle, because its count then stays at MAX_OUT.
  assign inst_room = (inst_cnt_reg < CW'(MAX_OUT)) ||
                     ((inst_cnt_reg == CW'(MAX_OUT)) && inst_retire);
  assign data_room = (data_cnt_reg < CW'(MAX_OUT)) ||
                     ((data_cnt_reg == CW'(MAX_OUT)) && data_retire);

  assign inst_elig  = !rst && inst_req && inst_room;
  assign data_elig  = !rst && data_req && data_room;
  assign force_inst = (starve_reg == SW'(ARB_STARVE));
  assign inst_grant = inst_elig && (!data_elig || force_inst);
  assign data_grant = data_elig && !inst_grant;
  assign accept     = inst_grant || data_grant;

  assign inst_addr_ok = inst_grant;
  assign data_addr_ok = data_grant;

  // Memory command. Every field is zero when no request is accepted.
  assign win_addr  = data_grant ? data_addr : (inst_grant ? inst_addr : 32'h0);
  assign mem_en    = accept;
  assign mem_wen   = data_grant ? data_wen : 4'b0000;
  assign mem_wdata = data_grant ? data_wdata : 32'h0;
`ifdef SRAM_ARB_KSEG_MAP_EN
  assign mem_addr  = {3'b000, win_addr[28:0]};
`else
  assign mem_addr  = win_addr;
`endif

  // Responses go only to the owner. A store acknowledges with zero data.
  assign inst_data_ok = inst_retire;
  assign data_data_ok = data_retire;
  assign inst_rdata   = (inst_retire && !tail_wr) ? mem_rdata : 32'h0;
  assign data_rdata   = (data_retire && !tail_wr) ? mem_rdata : 32'h0;

  // Shift network: stage 0 loads the access accepted this cycle, and every
  // later stage takes the value of the stage before it.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_next[gi] = accept;
        assign tag_owner_next[gi] = data_grant;
        assign tag_wr_next[gi]    = data_grant && (data_wen != 4'b0000);
      end else begin : g_shift
        assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        assign tag_owner_next[gi] = tag_owner_reg[gi-1];
        assign tag_wr_next[gi]    = tag_wr_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    inst_cnt_next = inst_cnt_reg;
    data_cnt_next = data_cnt_reg;
    starve_next   = starve_reg;
    // An accept and a retire in the same cycle cancel out.
    if (inst_grant && !inst_retire)      inst_cnt_next = inst_cnt_reg + CW'(1);
    else if (!inst_grant && inst_retire) inst_cnt_next = inst_cnt_reg - CW'(1);
    if (data_grant && !data_retire)      data_cnt_next = data_cnt_reg + CW'(1);
    else if (!data_grant && data_retire) data_cnt_next = data_cnt_reg - CW'(1);
    // Count only cycles where a waiting fetch actually loses to data.
    // The count saturates at ARB_STARVE.
    if (!inst_req || inst_grant)
      starve_next = '0;
    else if (data_grant && !force_inst)
      starve_next = starve_reg + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_reg <= '0;
      tag_owner_reg <= '0;
      tag_wr_reg    <= '0;
      inst_cnt_reg  <= '0;
      data_cnt_reg  <= '0;
      starve_reg    <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_owner_reg <= tag_owner_next;
      tag_wr_reg    <= tag_wr_next;
      inst_cnt_reg  <= inst_cnt_next;
      data_cnt_reg  <= data_cnt_next;
      starve_reg    <= starve_next;
    end
  end

endmodule
